// File: rtl/audio_axis_pkg.sv
// Shared definitions for the audio AXI-Stream path: sample width, stereo
// channel indices and the read-side state encoding of the stereo FIFO.
package audio_axis_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } fifo_rd_state_t;

endpackage

// File: rtl/stereo_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The read register only updates on i_rd_en, so it can serve directly as the
// held output word of the FIFO.
module stereo_fifo_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage write, no reset so it maps onto RAM primitives
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read, held between loads
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_stereo_fifo.sv
// Packet-aware stereo AXI-Stream FIFO. Words are written as L/R pairs; a
// pair becomes readable only once its right word is stored, and malformed
// framing is repaired on the write side so channels never swap.
// Optional build macro AXIS_STEREO_FIFO_LEVEL_EN adds the committed-packet
// level and its sticky high-water mark as outputs.
module axis_stereo_fifo
  import audio_axis_pkg::*;
#(
  parameter int DATA_WIDTH    = AUDIO_DATA_WIDTH,
  parameter int DEPTH_PACKETS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  framing_err
`ifdef AXIS_STEREO_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH_PACKETS):0] level,
  output logic [$clog2(DEPTH_PACKETS):0] high_water
`endif
);

  localparam int WORDS = 2 * DEPTH_PACKETS;
  localparam int AW    = $clog2(WORDS);
  localparam int PW    = AW + 1;
  localparam logic [PW-1:0] FULL_WORDS = PW'(WORDS);

  logic [PW-1:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [PW-1:0]  w_wr_ptr_nxt, w_commit_ptr_nxt, w_rd_ptr_nxt;
  logic           r_s_ready, r_framing_err, r_m_last;
  fifo_rd_state_t r_state, w_state_nxt;
  logic           w_wr_fire, w_ram_we, w_err, w_load;
  logic [AW-1:0]  w_ram_waddr, w_ld_addr;

  assign w_wr_fire = s_axis_valid & r_s_ready;

  // Write-side framing: compare each accepted word with the expected channel
  always_comb begin
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_ram_we         = 1'b0;
    w_ram_waddr      = r_wr_ptr[AW-1:0];
    w_err            = 1'b0;
    if (w_wr_fire) begin
      if (r_wr_ptr[0] == CH_LEFT) begin
        if (!s_axis_last) begin
          w_ram_we     = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        end else begin
          // orphan right word: dropped
          w_err = 1'b1;
        end
      end else begin
        if (s_axis_last) begin
          w_ram_we         = 1'b1;
          w_wr_ptr_nxt     = r_wr_ptr + PW'(1);
          w_commit_ptr_nxt = r_wr_ptr + PW'(1);
        end else begin
          // right word missing: the new word replaces the pending left word
          w_ram_we    = 1'b1;
          w_ram_waddr = {r_wr_ptr[AW-1:1], CH_LEFT};
          w_err       = 1'b1;
        end
      end
    end
  end

  // Read FSM next state; loads use the registered commit pointer so a word
  // is never read in the same cycle it is written
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_rd_ptr_nxt = r_rd_ptr;
    w_ld_addr    = r_rd_ptr[AW-1:0];
    case (r_state)
      EMPTY: begin
        if (r_commit_ptr != r_rd_ptr) begin
          w_load      = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (m_axis_ready) begin
          w_rd_ptr_nxt = r_rd_ptr + PW'(1);
          w_ld_addr    = w_rd_ptr_nxt[AW-1:0];
          if (r_commit_ptr != w_rd_ptr_nxt) w_load = 1'b1;
          else                              w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Pointers, registered input ready and framing pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_commit_ptr  <= '0;
      r_rd_ptr      <= '0;
      r_s_ready     <= 1'b1;
      r_framing_err <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_commit_ptr  <= w_commit_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_s_ready     <= (w_wr_ptr_nxt - w_rd_ptr_nxt) != FULL_WORDS;
      r_framing_err <= w_err;
    end
  end

  // Channel flag follows the address of the word being loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_m_last <= 1'b0;
    else if (w_load) r_m_last <= (w_ld_addr[0] == CH_RIGHT);
  end

  stereo_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (w_ram_waddr),
    .i_wr_data (s_axis_data),
    .i_rd_en   (w_load),
    .i_rd_addr (w_ld_addr),
    .o_rd_data (m_axis_data)
  );

  assign s_axis_ready = r_s_ready;
  assign m_axis_valid = (r_state == PRESENT);
  assign m_axis_last  = r_m_last;
  assign framing_err  = r_framing_err;

`ifdef AXIS_STEREO_FIFO_LEVEL_EN
  logic [AW-1:0] r_level, r_high_water, w_level_nxt;

  // Packets whose right word is committed but not yet read
  assign w_level_nxt = w_commit_ptr_nxt[PW-1:1] - w_rd_ptr_nxt[PW-1:1];

  // Level and its sticky maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level      <= '0;
      r_high_water <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_level_nxt > r_high_water) r_high_water <= w_level_nxt;
    end
  end

  assign level      = r_level;
  assign high_water = r_high_water;
`endif

endmodule

// File: tb/tb_axis_stereo_fifo.sv
module tb_axis_stereo_fifo;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last;
  logic          framing_err;
`ifdef AXIS_STEREO_FIFO_LEVEL_EN
  logic [3:0]    level, high_water;
`endif

  axis_stereo_fifo #(.DATA_WIDTH(DW), .DEPTH_PACKETS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready),
    .s_axis_last  (s_last),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_ready (m_ready),
    .m_axis_last  (m_last),
    .framing_err  (framing_err)
`ifdef AXIS_STEREO_FIFO_LEVEL_EN
    ,
    .level        (level),
    .high_water   (high_water)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  int          n_mark;
  logic [DW:0] sb_q[$];
  logic [DW:0] sb_exp;
  logic [DW-1:0] pend_data, hold_data, rnd_d;
  bit          pend_vld, exp_err, hold_prev, hold_last, rnd_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the FIFO accepts it
  task automatic send_word(input logic [DW-1:0] d, input logic l);
    int  budget = 1000;
    bit  got;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      got = s_ready;
      tick();
      if (got) break;
      budget--;
      if (budget == 0) begin
        chk("send_timeout", 32'(got), 32'(1));
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 300;
    while ((sb_q.size() != 0 || m_valid) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_queue", 32'(sb_q.size()), 32'(0));
    chk("drain_valid", 32'(m_valid), 32'(0));
  endtask

  // Reference model of the write-side framing plus output scoreboard,
  // sampled mid-cycle for the handshakes about to complete
  task automatic monitor_step();
    if (rst) begin
      sb_q.delete();
      pend_vld  = 1'b0;
      exp_err   = 1'b0;
      hold_prev = 1'b0;
      return;
    end
    chk("framing_err", 32'(framing_err), 32'(exp_err));
    exp_err = 1'b0;
    if (hold_prev) begin
      chk("hold_valid", 32'(m_valid), 32'(1));
      chk("hold_data", 32'(m_data), 32'(hold_data));
      chk("hold_last", 32'(m_last), 32'(hold_last));
    end
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    if (s_valid && s_ready) begin
      if (!pend_vld) begin
        if (s_last) exp_err = 1'b1;
        else begin
          pend_data = s_data;
          pend_vld  = 1'b1;
        end
      end else if (s_last) begin
        sb_q.push_back({1'b0, pend_data});
        sb_q.push_back({1'b1, s_data});
        pend_vld = 1'b0;
      end else begin
        pend_data = s_data;
        exp_err   = 1'b1;
      end
    end
    if (m_valid && m_ready) begin
      n_out++;
      if (sb_q.size() == 0) chk("out_expected", 32'(sb_q.size() != 0), 32'(1));
      else begin
        sb_exp = sb_q.pop_front();
        chk("out_data", 32'(m_data), 32'(sb_exp[DW-1:0]));
        chk("out_last", 32'(m_last), 32'(sb_exp[DW]));
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_s_ready", 32'(s_ready), 32'(1));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_last", 32'(m_last), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_ferr", 32'(framing_err), 32'(0));

    // four packets, sink always ready, commit-to-output latency
    m_ready = 1'b1;
    send_word(24'h000111, 1'b0);
    send_word(24'h000222, 1'b1);
    chk("lat_valid_k", 32'(m_valid), 32'(0));
    tick();
    chk("lat_valid_k1", 32'(m_valid), 32'(1));
    chk("lat_data", 32'(m_data), 32'h000111);
    chk("lat_last", 32'(m_last), 32'(0));
    send_word(24'h000333, 1'b0);
    send_word(24'h000444, 1'b1);
    send_word(24'h000555, 1'b0);
    send_word(24'h000666, 1'b1);
    send_word(24'h000777, 1'b0);
    send_word(24'h000888, 1'b1);
    wait_drain();
    chk("basic_count", 32'(n_out), 32'(8));

    // fill to capacity with sink stalled, then release (crosses the wrap)
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_word(24'h0A0000 | 24'(i), 1'(i % 2));
      if (i == 14) chk("fill_ready_15", 32'(s_ready), 32'(1));
    end
    chk("fill_ready_16", 32'(s_ready), 32'(0));
    chk("fill_head_valid", 32'(m_valid), 32'(1));
    chk("fill_head_data", 32'(m_data), 32'h0A0000);
`ifdef AXIS_STEREO_FIFO_LEVEL_EN
    chk("fill_level", 32'(level), 32'(8));
    chk("fill_high_water", 32'(high_water), 32'(8));
`endif
    s_data  = 24'hBADBAD;
    s_last  = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("full_hold_ready", 32'(s_ready), 32'(0));
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("free_ready_rise", 32'(s_ready), 32'(1));
    wait_drain();

    // orphan right word is dropped, next packet intact
    n_mark = n_out;
    send_word(24'h7FFFFF, 1'b1);
    chk("orphan_err", 32'(framing_err), 32'(1));
    send_word(24'h000AAA, 1'b0);
    send_word(24'h000BBB, 1'b1);
    wait_drain();
    chk("orphan_count", 32'(n_out - n_mark), 32'(2));

    // missing right word: second left replaces the first
    n_mark = n_out;
    send_word(24'h100000, 1'b0);
    send_word(24'h200000, 1'b0);
    chk("relead_err", 32'(framing_err), 32'(1));
    send_word(24'h300000, 1'b1);
    wait_drain();
    chk("relead_count", 32'(n_out - n_mark), 32'(2));

    // random valid/ready traffic over many pointer wraps
    n_mark   = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 2000; p++) begin
          while ($urandom_range(1) == 1) tick();
          rnd_d = 24'($urandom);
          send_word(rnd_d, 1'b0);
          while ($urandom_range(1) == 1) tick();
          rnd_d = 24'($urandom);
          send_word(rnd_d, 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          m_ready = 1'($urandom_range(1));
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();
    chk("rand_count", 32'(n_out - n_mark), 32'(4000));

    // reset with a committed packet and a pending left word stored
    m_ready = 1'b0;
    send_word(24'h0C0001, 1'b0);
    send_word(24'h0C0002, 1'b1);
    send_word(24'h0C0003, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(m_valid), 32'(1));
`ifdef AXIS_STEREO_FIFO_LEVEL_EN
    chk("pre_rst_level", 32'(level), 32'(1));
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", 32'(s_ready), 32'(1));
    chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
    chk("mid_rst_m_last", 32'(m_last), 32'(0));
    chk("mid_rst_m_data", 32'(m_data), 32'(0));
    chk("mid_rst_ferr", 32'(framing_err), 32'(0));
`ifdef AXIS_STEREO_FIFO_LEVEL_EN
    chk("mid_rst_level", 32'(level), 32'(0));
    chk("mid_rst_high_water", 32'(high_water), 32'(0));
`endif
    tick();
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    n_mark = n_out;
    send_word(24'h0D0001, 1'b0);
    send_word(24'h0D0002, 1'b1);
    wait_drain();
    chk("post_rst_count", 32'(n_out - n_mark), 32'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
